uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver that deserialises the board RS-232 line into bytes and pushes them into the 32-entry rx FIFO consumed by uart_control.
- Format: fixed 8N1, LSB first, idle-high line.
- Asynchronous rxd is synchronised internally.
- Line errors (false start, framing, FIFO overrun) are flagged as single-cycle pulses for status/debug logic.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per bit (100 MHz / 115200). Legal range ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2: derived localparam; start-bit mid-point offset.

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous reset, active-high
- rxd  input  1  asynchronous serial input, idle high
- rx_fifo_data  output  8  received byte; valid while rx_fifo_write_enable=1
- rx_fifo_write_enable  output  1  one-cycle write strobe into rx FIFO
- rx_fifo_full  input  1  rx FIFO full; a byte completed while high is dropped
- rx_busy  output  1  high in every state except IDLE
- frame_error  output  1  one-cycle pulse: stop bit sampled low
- overrun_error  output  1  one-cycle pulse: good byte dropped because FIFO full

Behaviour:
- Reset values:
  - Outputs: rx_fifo_data=0, rx_fifo_write_enable=0, rx_busy=0, frame_error=0, overrun_error=0.
  - Internal: state=IDLE, synchroniser flops=1, counters=0.
  - Reset mid-frame abandons the frame; nothing is written.
- Synchroniser: two flops on rxd, producing rxd_s; adds 2 cycles latency. No further filtering.
- Baud counter: width clog2(CLKS_PER_BIT); cleared on every state entry. Bit counter: 3 bits.
- IDLE:
  - rxd_s=0 → START, counter cleared.
- START:
  - Samples rxd_s when counter==HALF_BIT-1.
  - Sample 0 → DATA, counter cleared, bit index 0.
  - Sample 1 → false start; return to IDLE, no error pulse.
- DATA:
  - Samples when counter==CLKS_PER_BIT-1; sampled bit shifts into bit[index], LSB first.
  - After index 7 → STOP, else index+1.
- STOP:
  - Samples when counter==CLKS_PER_BIT-1.
  - Sample 1, FIFO not full: rx_fifo_data=byte and rx_fifo_write_enable=1 on the next cycle, for exactly one cycle → IDLE.
  - Sample 1, rx_fifo_full=1 (value at the sample cycle): no write; overrun_error pulses 1 cycle → IDLE.
  - Sample 0: no write; frame_error pulses 1 cycle → WAIT_IDLE.
- WAIT_IDLE:
  - Stays until rxd_s=1, then → IDLE.
  - A held-low line (break) therefore produces exactly one frame_error.
- Back-to-back frames: IDLE is re-entered before the next start edge arrives, because stop sampling happens mid-bit. A start edge seen in IDLE on the cycle right after STOP must be accepted.
- rx_fifo_data holds its last value between strobes.
- Simultaneous events: write strobe and error pulses are mutually exclusive by construction.
- Timing: data latency from the stop-bit mid-point at the pin to the write strobe = 2 (sync) + 1 cycles.

Decomposition:
- Shared header uart_defs.vh:
  - State encodings: IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4; 3-bit.
  - DEFAULT_CLKS_PER_BIT=868.
  - Reused by uart_tx and uart_control.
- One natural sub-module: sync_bit (2-flop synchroniser, parameterised reset value), reused for other async inputs.

Test Plan (CLKS_PER_BIT=16 in simulation, 1 bit = 16 clk):
- Single frame 0xA5, FIFO not full → exactly one rx_fifo_write_enable pulse with rx_fifo_data=0xA5; frame_error and overrun_error stay 0. Strobe occurs 3 cycles after the stop-bit mid-point on rxd.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap → three strobes carrying 0x00, 0xFF, 0x55, in order, no errors.
- rxd low glitch of 5 cycles (< HALF_BIT) → no strobe, no error; rx_busy returns to 0 within 8 cycles of the glitch.
- Frame 0x3C with stop bit forced 0, then line held low for 40 bits → one frame_error pulse, no strobe, rx_busy stays 1. After rxd returns high and a valid frame 0x81 is sent, exactly one strobe with 0x81.
- rx_fifo_full=1 during frame 0x7E stop sample → overrun_error pulses once, no strobe. Deassert full and send 0x7F → strobe with 0x7F.
- Assert rst for 1 cycle at data bit 4 of frame 0x12 → no strobe for that frame; all outputs 0 next cycle. A following valid frame 0x34 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: FSM state encoding and default baud divisor.
// Encodings are fixed so uart_tx and uart_control can decode the same values.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchroniser for one asynchronous input bit.
// Flops reset to RESET_VALUE so an idle line does not glitch out of reset.
module sync_bit #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver feeding the rx FIFO; samples each bit at its mid-point.
// Line errors are reported as single-cycle pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_fifo_data,
    output logic       rx_fifo_write_enable,
    input  logic       rx_fifo_full,
    output logic       rx_busy,
    output logic       frame_error,
    output logic       overrun_error
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t HALF_LAST = cnt_t'(HALF_BIT - 1);
    localparam cnt_t BIT_LAST  = cnt_t'(CLKS_PER_BIT - 1);

    logic rxd_s;

    rx_state_t  state, state_n;
    cnt_t       cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] shift, shift_n;
    logic [7:0] data_q, data_n;
    logic       we_q, we_n;
    logic       fe_q, fe_n;
    logic       oe_q, oe_n;

    sync_bit #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shift  <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            fe_q   <= 1'b0;
            oe_q   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shift  <= shift_n;
            data_q <= data_n;
            we_q   <= we_n;
            fe_q   <= fe_n;
            oe_q   <= oe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shift_n = shift;
        data_n  = data_q;
        we_n    = 1'b0;
        fe_n    = 1'b0;
        oe_n    = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxd_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n        = '0;
                    shift_n[idx] = rxd_s;
                    if (idx == 3'd7) state_n = STOP;
                    else idx_n = idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (!rxd_s) begin
                        fe_n    = 1'b1;
                        state_n = WAIT_IDLE;
                    end else begin
                        state_n = IDLE;
                        if (rx_fifo_full) begin
                            oe_n = 1'b1;
                        end else begin
                            we_n   = 1'b1;
                            data_n = shift;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low break stays here so it yields one error only
                cnt_n = '0;
                if (rxd_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign rx_fifo_data         = data_q;
    assign rx_fifo_write_enable = we_q;
    assign frame_error          = fe_q;
    assign overrun_error        = oe_q;
    assign rx_busy              = (state != IDLE);

endmodule
